pc_irq_unit: RTL
================

# pc_irq_unit

Parametrised program-counter sequencer for the next-generation MIPS core. It owns the PC, the EPC and the cause register, and it latches N maskable interrupt lines. It resolves the next PC each cycle from sequential, branch, jump, register-jump, exception-return, overflow-exception and interrupt sources, and it holds state while the core stalls on memory wait states. It sits between instruction ROM addressing and the controller; the controller uses oTakeIrq/oTakeExc to squash the current instruction's register and memory writes.

## Interface
- RESET_VEC, 32'h80000000, PC value loaded on reset
- IRQ_VEC, 32'h80000004, interrupt entry address
- EXC_VEC, 32'h80000008, overflow-exception entry address
- N_IRQ, 4, number of interrupt channels, legal range 1..16
- KBIT, 31, PC bit used as the kernel-mode flag

Ports (name, direction, width, meaning):
- clk, in, 1, clock; all state updates on the rising edge
- reset, in, 1, asynchronous, active-low
- iStall, in, 1, 1 = hold PC, EPC, cause and pending-clear this cycle
- iPCSrc, in, 2, 00 sequential, 01 branch, 10 jump, 11 register jump
- iBranchTaken, in, 1, branch condition result
- iBranchOffset, in, 32, sign-extended immediate in words (not shifted)
- iJumpIndex, in, 26, J-format target field
- iRegTarget, in, 32, rs value for jr/jalr
- iEret, in, 1, exception return
- iOverflow, in, 1, ALU overflow for the current instruction
- iIrq, in, N_IRQ, interrupt request levels
- iIrqMask, in, N_IRQ, 1 = channel enabled
- oPC, out, 32, current PC
- oPCPlus4, out, 32, oPC + 4
- oEPC, out, 32, address to resume at
- oCause, out, 5, bit 4: 1 = IRQ, 0 = overflow; bits 3:0 = channel index
- oTakeIrq, out, 1, interrupt accepted this cycle
- oTakeExc, out, 1, overflow exception accepted this cycle
- oKernel, out, 1, equals oPC[KBIT]

## Operation
- Reset values: oPC = RESET_VEC, oEPC = 0, oCause = 0, pending = 0, so oTakeIrq = 0 and oTakeExc = 0.
- Pending register, per channel i, updated every edge regardless of iStall:
  - pending[i] <= (pending[i] | iIrq[i]) & ~clr[i].
  - clr[i] = 1 only when channel i is taken this cycle.
  - Clear wins over a simultaneous set for the taken channel.
- Exception acceptance: oTakeExc = iOverflow & ~iStall. It is accepted in both modes.
- Interrupt acceptance: oTakeIrq = ~oKernel & |(pending & iIrqMask) & ~iStall & ~iOverflow.
  - When both are eligible, the overflow exception has priority over the interrupt.
  - The lowest-index pending, enabled channel is the one taken.
- Next-PC priority, highest first:
  1. oTakeExc → EXC_VEC.
  2. oTakeIrq → IRQ_VEC.
  3. iEret → {1'b0 at KBIT, oEPC elsewhere}; returns to user mode.
  4. iPCSrc = 11 → iRegTarget. This is the only normal flow allowed to change KBIT.
  5. iPCSrc = 10 → {oPCPlus4[31:28], iJumpIndex, 2'b00}.
  6. iPCSrc = 01 and iBranchTaken → oPCPlus4 + (iBranchOffset << 2), 32-bit wrap.
  7. Otherwise → oPCPlus4. This includes an untaken branch.
- For sources 5 and 6 (and the sequential case), bit KBIT of the result is forced to the current oKernel.
- On take:
  - oEPC <= oPC; the squashed instruction restarts on return.
  - oCause <= {1'b0, 4'd0} for an overflow exception, {1'b1, index} for an interrupt.
- iStall = 1: oPC, oEPC and oCause hold; iPCSrc, iEret and iOverflow are ignored; pending still captures new requests.
- oPCPlus4 wraps 32'hFFFFFFFC → 0.

## Timing
- Acceptance signals are combinational from registered state and the current inputs. PC, EPC and cause update on the following rising edge.
- Interrupt latency, user mode, no stall:
  - iIrq rises in cycle n.
  - pending is set at edge n+1.
  - oTakeIrq = 1 in cycle n+1.
  - oPC = IRQ_VEC after edge n+2.
- Kernel mode masks all interrupts. A pending request waits until iEret clears KBIT, then it is taken in the first user-mode cycle.
- Reset assertion mid-operation immediately forces all reset values asynchronously. The first fetch after deassertion is RESET_VEC.
- Single-cycle throughput: one PC update per unstalled cycle.

## Test plan
- Reset and sequence: release reset, iPCSrc = 00 for 3 cycles → oPC = 80000000, 80000004, 80000008, 8000000C; oKernel = 1.
- Branch and jump in user mode: start at oPC = 00400000.
  - iPCSrc = 01, iBranchTaken = 1, offset = -2 → oPC = 003FFFFC.
  - Then iPCSrc = 10, index = 0x0100010 → 00400040.
  - KBIT stays 0 throughout.
- IRQ priority: user mode, iIrq = 4'b1010, mask = 4'b1111.
  - oTakeIrq in the second cycle; oCause = 5'b10001; oEPC = interrupted PC; oPC = 80000004.
  - pending[1] clears; pending[3] remains.
- Kernel masking and return: take an IRQ and keep iIrq[2] high while in kernel → no take.
  - iEret → oPC = oEPC with bit 31 = 0.
  - The next cycle takes channel 2.
- Overflow versus IRQ: iOverflow = 1 with an enabled pending channel → oTakeExc = 1, oTakeIrq = 0, oPC = 80000008, oCause = 0, the channel stays pending.
- Stall and async reset:
  - iStall = 1 for 3 cycles with an IRQ arriving → oPC frozen, pending set, taken the first unstalled cycle.
  - Asserting reset mid-stall → oPC = 80000000 without a clock edge.

Source files
------------

// File: rtl/pc_irq_unit.sv
// pc_irq_unit: program-counter sequencer owning PC, EPC and cause, with N latched maskable interrupts.
module pc_irq_unit #(
  parameter logic [31:0] RESET_VEC = 32'h80000000,
  parameter logic [31:0] IRQ_VEC   = 32'h80000004,
  parameter logic [31:0] EXC_VEC   = 32'h80000008,
  parameter int          N_IRQ     = 4,
  parameter int          KBIT      = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iStall,
  input  logic [1:0]       iPCSrc,
  input  logic             iBranchTaken,
  input  logic [31:0]      iBranchOffset,
  input  logic [25:0]      iJumpIndex,
  input  logic [31:0]      iRegTarget,
  input  logic             iEret,
  input  logic             iOverflow,
  input  logic [N_IRQ-1:0] iIrq,
  input  logic [N_IRQ-1:0] iIrqMask,
  output logic [31:0]      oPC,
  output logic [31:0]      oPCPlus4,
  output logic [31:0]      oEPC,
  output logic [4:0]       oCause,
  output logic             oTakeIrq,
  output logic             oTakeExc,
  output logic             oKernel
);
  localparam logic [31:0] KMASK = 32'h1 << KBIT;
  logic [31:0] pc, epc, flow_pc, next_pc;
  logic [4:0] cause;
  logic [N_IRQ-1:0] pending, eligible, clr;
  logic [3:0] idx;
  assign oPC = pc;
  assign oPCPlus4 = pc + 32'd4;
  assign oEPC = epc;
  assign oCause = cause;
  assign oKernel = pc[KBIT];
  assign eligible = pending & iIrqMask;
  assign oTakeExc = iOverflow & ~iStall;
  assign oTakeIrq = ~oKernel & (|eligible) & ~iStall & ~iOverflow;
  // two's-complement trick isolates the lowest set bit: the channel being taken
  assign clr = oTakeIrq ? (eligible & (~eligible + N_IRQ'(1))) : '0;
  always_comb begin
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) if (eligible[i]) idx = 4'(i);
  end
  // jumps, branches and sequential flow may never change the kernel flag
  assign flow_pc = iPCSrc == 2'b10 ? {oPCPlus4[31:28], iJumpIndex, 2'b00}
                 : (iPCSrc == 2'b01 && iBranchTaken) ? oPCPlus4 + {iBranchOffset[29:0], 2'b00}
                 : oPCPlus4;
  assign next_pc = oTakeExc ? EXC_VEC
                 : oTakeIrq ? IRQ_VEC
                 : iEret ? (epc & ~KMASK)
                 : iPCSrc == 2'b11 ? iRegTarget
                 : (flow_pc & ~KMASK) | (oKernel ? KMASK : 32'd0);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_VEC;
      epc <= '0;
      cause <= '0;
      pending <= '0;
    end else begin
      pending <= (pending | iIrq) & ~clr;
      if (!iStall) begin
        pc <= next_pc;
        if (oTakeExc || oTakeIrq) begin
          epc <= pc;
          cause <= oTakeExc ? 5'd0 : {1'b1, idx};
        end
      end
    end
  end
endmodule
